bsg_relay_arb_rr: RTL and testbench
===================================

Name: bsg_relay_arb_rr
Overview: Round-robin arbiter that shares one downstream relay FIFO between N requesters. Each requester has a valid/ready (ready-then-valid) input channel. A granted requester may hold the grant for a burst of up to MAX_BURST_P beats, then must release it. The winning channel is forwarded to a single valid/ready output that feeds the relay FIFO, and the block reports which requester owns each beat.

Parameters:
els_p, 4, number of requesters (2..16)
width_p, 16, data width per beat
max_burst_p, 4, max consecutive beats one requester may send before rotation (>=1)
lg_els_lp, $clog2(els_p), width of the owner ID (derived, not overridable)

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_i  in  1  asynchronous, active-high reset
v_i  in  els_p  per-requester valid
data_i  in  els_p*width_p  per-requester data, requester k at bits [k*width_p +: width_p]
ready_o  out  els_p  per-requester ready; one-hot or zero
v_o  out  1  valid toward the relay FIFO
data_o  out  width_p  selected data
id_o  out  lg_els_lp  index of the requester driving data_o
ready_i  in  1  relay FIFO ready_o
busy_o  out  1  a burst is in progress (grant is locked)

Behaviour:
- Handshake: a beat transfers when v_o & ready_i; the selected requester's v_i & ready_o is the same event. No transfer may ever be dropped or duplicated.
- State: last_r (lg_els_lp bits), locked_r (1), owner_r (lg_els_lp bits), cnt_r (counts beats in the burst, saturates at max_burst_p).
- Reset (asynchronous): last_r=els_p-1, locked_r=0, owner_r=0, cnt_r=0. During reset: v_o=0, ready_o=0, busy_o=0, id_o=0.
- IDLE (locked_r=0): the grant goes to the first requester with v_i set, searching from last_r+1 upward and wrapping modulo els_p. Search and grant are combinational in the same cycle, so there are zero cycles of latency from v_i to v_o. If no v_i is set: v_o=0, ready_o=0, and data_o/id_o are don't-care (driven to 0).
- On a transfer in IDLE: if max_burst_p>1, set locked_r=1, owner_r=winner, cnt_r=1. If max_burst_p==1, set last_r=winner and stay in IDLE.
- LOCKED: only owner_r is considered. v_o=v_i[owner_r]; ready_o[owner_r]=ready_i; id_o=owner_r; busy_o=1.
  - On each transfer, cnt_r increments.
  - If cnt_r reaches max_burst_p on that transfer, clear locked_r, set last_r=owner_r, and clear cnt_r.
  - If the owner drops v_i for a cycle while locked, release: locked_r=0, last_r=owner_r, cnt_r=0. Arbitration happens next cycle; no beat transfers in the release cycle.
- Backpressure: while ready_i=0 the grant holds. Neither the IDLE winner nor cnt_r changes because of a stalled beat.
- A requester cannot be locked out: every requester with v_i held set is served within (els_p-1)*max_burst_p beats.
- Wrap-around: the search from last_r=els_p-1 starts at index 0.
- Reset asserted mid-burst: all state and outputs return to reset values immediately. Upstream must reissue its data.
- ready_o depends combinationally on ready_i. v_o never depends on ready_i.

Test Plan:
- Reset, then v_i=4'b1111 and ready_i=1 held, els_p=4, max_burst_p=4 -> id_o sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; busy_o=1 on beats 2-4 of each burst.
- v_i=4'b0101, max_burst_p=1 -> id_o alternates 0,2,0,2; ready_o is 0001 then 0100.
- Requester 1 granted, sends 2 beats, then drops v_i while v_i[3]=1 -> one idle cycle with v_o=0, then id_o=3. After the next release the search starts at 0.
- Requester 2 granted with ready_i=0 for 5 cycles -> v_o=1, id_o=2, data_o stable, cnt_r unchanged. Burst completes after 4 accepted beats.
- Reset asserted asynchronously mid-burst (cnt_r=2) -> v_o, ready_o, and busy_o go to 0 before the next clock edge. After release, the first grant goes to the lowest index with v_i set.
- Scoreboard run with random v_i/ready_i for 10k cycles -> per-requester data order is preserved, and no requester waits more than 12 beats with v_i held.

Source files
------------

// File: rtl/bsg_relay_arb_rr.sv
// bsg_relay_arb_rr: round-robin arbiter sharing one relay FIFO between
// els_p requesters, with grants locked for bursts of up to max_burst_p beats.
module bsg_relay_arb_rr #(
   parameter int els_p       = 4,
   parameter int width_p     = 16,
   parameter int max_burst_p = 4,
   localparam int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   output logic [lg_els_lp-1:0]     id_o,
   input  logic                     ready_i,
   output logic                     busy_o
);

   localparam int cnt_w_lp = $clog2(max_burst_p + 1);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_e;

   state_e                state_q, state_d;
   logic [lg_els_lp-1:0]  last_q, last_d;
   logic [lg_els_lp-1:0]  owner_q, owner_d;
   logic [cnt_w_lp-1:0]   cnt_q, cnt_d;

   logic                  found;
   logic [lg_els_lp-1:0]  winner;
   logic [lg_els_lp-1:0]  cand;
   int                    idx;

   logic                  locked;
   logic [lg_els_lp-1:0]  sel;
   logic                  sel_live;
   logic                  xfer;

   assign locked = (state_q == ST_LOCKED);

   // rotating-priority search, starting just after the last served requester
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int i = 1; i <= els_p; i++) begin
         idx  = (int'(last_q) + i) % els_p;
         cand = lg_els_lp'(idx);
         if (!found && v_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // steer the locked owner, or the fresh winner, onto the relay channel
   always_comb begin
      sel      = locked ? owner_q : winner;
      sel_live = ~reset_i & (locked | found);
      v_o      = sel_live & v_i[sel];
      ready_o  = '0;
      data_o   = '0;
      for (int k = 0; k < els_p; k++) begin
         if (sel_live && (sel == lg_els_lp'(k))) begin
            ready_o[k] = ready_i;
            data_o     = data_i[k*width_p +: width_p];
         end
      end
      id_o   = sel_live ? sel : '0;
      busy_o = ~reset_i & locked;
      xfer   = v_o & ready_i;
   end

   // burst lock / release and rotation pointer update
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               if (max_burst_p > 1) begin
                  state_d = ST_LOCKED;
                  owner_d = winner;
                  cnt_d   = cnt_w_lp'(1);
               end else begin
                  last_d = winner;
               end
            end
         end
         ST_LOCKED: begin
            if (!v_i[owner_q]) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
               cnt_d   = '0;
            end else if (xfer) begin
               if (cnt_q == cnt_w_lp'(max_burst_p - 1)) begin
                  state_d = ST_IDLE;
                  last_d  = owner_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + cnt_w_lp'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state register; reset abandons any burst in flight
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         last_q  <= lg_els_lp'(els_p - 1);
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bsg_relay_arb_rr.sv
// tb_bsg_relay_arb_rr: directed vectors plus a burst-level reference model
// for a max_burst_p=4 instance (a) and a max_burst_p=1 instance (b).
module tb_bsg_relay_arb_rr;

   logic        clk     = 1'b0;
   logic        reset_i = 1'b1;
   logic [3:0]  v_i     = '0;
   logic [63:0] data_i;
   logic        ready_i = 1'b0;

   logic [3:0]  ready_o_a, ready_o_b;
   logic        v_o_a, v_o_b;
   logic [15:0] data_o_a, data_o_b;
   logic [1:0]  id_o_a, id_o_b;
   logic        busy_a, busy_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] seq [4];
   logic [11:0] rx [4];
   int          wait_b [4];
   bit          sb_en = 1'b0;
   logic [3:0]  acc;

   int m_prev [2];
   int m_own [2];
   int m_beats [2];
   bit m_lock [2];
   int mb [2] = '{4, 1};

   int          c_pick, t;
   logic [1:0]  c_idx;
   logic        c_v;
   logic [3:0]  c_rdy;
   logic        c_x;
   logic        a_v, a_busy;
   logic [3:0]  a_rdy;
   logic [1:0]  a_id;
   logic [15:0] a_data;

   int   exp_id1 [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
   logic [3:0] t3_v [8] = '{4'b1010,4'b1010,4'b1000,4'b1000,
                            4'b1000,4'b1000,4'b1000,4'b1011};
   int   t3_ev [8] = '{1,1,0,1,1,1,1,1};
   int   t3_id [8] = '{1,1,1,3,3,3,3,0};
   int   t4_r [12] = '{0,0,0,0,0,1,1,0,0,1,1,1};
   int   t4_b [12] = '{0,0,0,0,0,0,1,1,1,1,1,0};

   bsg_relay_arb_rr #(.els_p(4), .width_p(16), .max_burst_p(4)) dut_a (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o_a),
      .v_o     (v_o_a),
      .data_o  (data_o_a),
      .id_o    (id_o_a),
      .ready_i (ready_i),
      .busy_o  (busy_a)
   );

   bsg_relay_arb_rr #(.els_p(4), .width_p(16), .max_burst_p(1)) dut_b (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o_b),
      .v_o     (v_o_b),
      .data_o  (data_o_b),
      .id_o    (id_o_b),
      .ready_i (ready_i),
      .busy_o  (busy_b)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic update_data();
      for (int k = 0; k < 4; k++)
         data_i[k*16 +: 16] = {4'(k), seq[k]};
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      v_i     = '0;
      @(negedge clk);
      @(posedge clk);
      #1 reset_i = 1'b0;
   endtask

   // reference model: who owns the channel and how many beats it has sent
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         a_v    = (i == 0) ? v_o_a : v_o_b;
         a_rdy  = (i == 0) ? ready_o_a : ready_o_b;
         a_id   = (i == 0) ? id_o_a : id_o_b;
         a_busy = (i == 0) ? busy_a : busy_b;
         a_data = (i == 0) ? data_o_a : data_o_b;
         if (reset_i) begin
            m_prev[i]  = 3;
            m_lock[i]  = 1'b0;
            m_own[i]   = 0;
            m_beats[i] = 0;
            check($sformatf("rst_v[%0d]", i), a_v, 0);
            check($sformatf("rst_ready[%0d]", i), a_rdy, 0);
            check($sformatf("rst_busy[%0d]", i), a_busy, 0);
            check($sformatf("rst_id[%0d]", i), a_id, 0);
         end else begin
            c_pick = -1;
            if (m_lock[i]) c_pick = m_own[i];
            else begin
               for (int j = 1; j <= 4; j++) begin
                  t = (m_prev[i] + j) % 4;
                  if (c_pick < 0 && v_i[t[1:0]]) c_pick = t;
               end
            end
            c_idx = c_pick[1:0];
            c_v   = 1'b0;
            c_rdy = '0;
            if (c_pick >= 0) begin
               c_v          = v_i[c_idx];
               c_rdy[c_idx] = ready_i;
            end
            c_x = c_v & ready_i;
            check($sformatf("v_o[%0d]", i), a_v, c_v);
            check($sformatf("ready_o[%0d]", i), a_rdy, c_rdy);
            check($sformatf("busy_o[%0d]", i), a_busy, m_lock[i]);
            if (c_pick >= 0)
               check($sformatf("id_o[%0d]", i), a_id, c_idx);
            if (c_v)
               check($sformatf("data_o[%0d]", i), a_data,
                     data_i[c_idx*16 +: 16]);
            if (i == 0 && sb_en && c_x) begin
               check("sb_order", a_data[11:0], rx[c_idx]);
               rx[c_idx]++;
               for (int q = 0; q < 4; q++) begin
                  if (q != c_pick) begin
                     if (v_i[q]) wait_b[q]++;
                     else wait_b[q] = 0;
                     check($sformatf("starve%0d", q), wait_b[q] <= 12, 1);
                  end
               end
               wait_b[c_idx] = 0;
            end
            if (m_lock[i]) begin
               if (!v_i[m_own[i][1:0]]) begin
                  m_lock[i]  = 1'b0;
                  m_prev[i]  = m_own[i];
                  m_beats[i] = 0;
               end else if (c_x) begin
                  m_beats[i]++;
                  if (m_beats[i] == mb[i]) begin
                     m_lock[i]  = 1'b0;
                     m_prev[i]  = m_own[i];
                     m_beats[i] = 0;
                  end
               end
            end else if (c_x) begin
               if (mb[i] > 1) begin
                  m_lock[i]  = 1'b1;
                  m_own[i]   = c_pick;
                  m_beats[i] = 1;
               end else begin
                  m_prev[i] = c_pick;
               end
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) seq[k] = 12'h100 + 12'(k);
      update_data();

      // reset with every requester asking: outputs must stay quiet
      v_i     = 4'hF;
      ready_i = 1'b1;
      @(negedge clk);
      check("reset_v_o", v_o_a, 0);
      check("reset_ready_o", ready_o_a, 0);
      @(posedge clk);
      #1 reset_i = 1'b0;

      // all requesting: bursts of four in index order
      for (int n = 0; n < 17; n++) begin
         @(negedge clk);
         check("t1_id", id_o_a, exp_id1[n]);
         check("t1_busy", busy_a, (n % 4) != 0);
         @(posedge clk);
         #1;
      end

      // max_burst 1 instance alternates between 0 and 2
      do_reset();
      v_i     = 4'b0101;
      ready_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("t2_id", id_o_b, (n % 2) ? 2 : 0);
         check("t2_ready", ready_o_b, (n % 2) ? 4'b0100 : 4'b0001);
         @(posedge clk);
         #1;
      end

      // owner drops valid mid-burst: one idle cycle, then rotation
      do_reset();
      ready_i = 1'b1;
      for (int n = 0; n < 8; n++) begin
         v_i = t3_v[n];
         @(negedge clk);
         check("t3_v", v_o_a, t3_ev[n]);
         check("t3_id", id_o_a, t3_id[n]);
         @(posedge clk);
         #1;
      end

      // backpressure holds the grant and does not consume beats
      do_reset();
      v_i = 4'b0100;
      for (int n = 0; n < 12; n++) begin
         ready_i = t4_r[n][0];
         @(negedge clk);
         check("t4_v", v_o_a, 1);
         check("t4_id", id_o_a, 2);
         check("t4_data", data_o_a, {4'd2, seq[2]});
         check("t4_busy", busy_a, t4_b[n]);
         check("t4_ready", ready_o_a, t4_r[n][0] ? 4'b0100 : 4'b0000);
         @(posedge clk);
         #1;
      end

      // asynchronous reset in the middle of a burst
      do_reset();
      v_i     = 4'hF;
      ready_i = 1'b1;
      repeat (2) begin
         @(negedge clk);
         @(posedge clk);
      end
      #1 check("t5_busy_pre", busy_a, 1);
      #2 reset_i = 1'b1;
      #1;
      check("t5_v_o", v_o_a, 0);
      check("t5_ready_o", ready_o_a, 0);
      check("t5_busy", busy_a, 0);
      check("t5_v_o_b", v_o_b, 0);
      @(negedge clk);
      @(posedge clk);
      #1 reset_i = 1'b0;
      v_i = 4'b0110;
      @(negedge clk);
      check("t5_first_v", v_o_a, 1);
      check("t5_first_id", id_o_a, 1);
      check("t5_first_id_b", id_o_b, 1);
      @(posedge clk);
      #1;

      // random traffic with valid held until accepted
      do_reset();
      for (int k = 0; k < 4; k++) begin
         seq[k]    = '0;
         rx[k]     = '0;
         wait_b[k] = 0;
      end
      update_data();
      sb_en = 1'b1;
      repeat (10000) begin
         @(negedge clk);
         acc = v_i & ready_o_a;
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
               seq[k]++;
               v_i[k] = ($urandom_range(0, 3) != 0);
            end else if (!v_i[k]) begin
               v_i[k] = ($urandom_range(0, 2) == 0);
            end
         end
         ready_i = ($urandom_range(0, 3) != 0);
         update_data();
      end
      @(negedge clk);
      sb_en = 1'b0;
      v_i   = '0;
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
